// File: rtl/lut_cfg_pkg.sv
// Shared types and sizing helpers for the LUT configuration loader.
package lut_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CHECK,
        WRITE,
        DONE
    } state_t;

    localparam int LUT_INPUTS_DEFAULT = 4;

    function automatic int lut_depth(input int lut_inputs);
        return 1 << lut_inputs;
    endfunction

endpackage

// File: rtl/lut_cfg_loader_if.sv
// Stream-in / LUT-write signal bundle of the configuration loader.
interface lut_cfg_loader_if #(
    parameter int LUT_INPUTS = lut_cfg_pkg::LUT_INPUTS_DEFAULT
);
    logic                  i_start;
    logic                  i_bit_valid;
    logic                  i_bit;
    logic [LUT_INPUTS-1:0] o_addr;
    logic                  o_data;
    logic                  o_config_enable;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_err;

    modport master (
        output i_start, i_bit_valid, i_bit,
        input  o_addr, o_data, o_config_enable, o_busy, o_done, o_err
    );

    modport slave (
        input  i_start, i_bit_valid, i_bit,
        output o_addr, o_data, o_config_enable, o_busy, o_done, o_err
    );
endinterface

// File: rtl/lut_cfg_shift_reg.sv
// Indexed capture buffer for one truth table, with a random-access read port for the write sweep.
// Build option: LUT_CFG_PARITY_EN adds a reduction-parity output over the whole table.
module lut_cfg_shift_reg
    import lut_cfg_pkg::*;
#(
    parameter int LUT_INPUTS = LUT_INPUTS_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [LUT_INPUTS-1:0] wr_idx,
    input  logic                  wr_bit,
    input  logic [LUT_INPUTS-1:0] rd_idx,
    output logic                  rd_bit
`ifdef LUT_CFG_PARITY_EN
    ,
    output logic                  parity
`endif
);
    localparam int DEPTH = lut_depth(LUT_INPUTS);

    logic [DEPTH-1:0] buffer;

    // NOTE: the buffer is a flop array, not a RAM, so clearing it on reset is cheap and keeps a
    // reset-then-sweep deterministic.
    always_ff @(posedge clk) begin
        if (rst) begin
            buffer <= '0;
        end else if (wr_en) begin
            buffer[wr_idx] <= wr_bit;
        end
    end

    assign rd_bit = buffer[rd_idx];

`ifdef LUT_CFG_PARITY_EN
    assign parity = ^buffer;
`endif

endmodule

// File: rtl/lut_cfg_loader.sv
// Serial truth-table loader feeding a LUT cell: capture, optional parity check, write sweep.
// Build option: define LUT_CFG_PARITY_EN to append and check an even-parity bit per frame.
module lut_cfg_loader
    import lut_cfg_pkg::*;
#(
    parameter int LUT_INPUTS = LUT_INPUTS_DEFAULT,
    parameter int WR_HOLD    = 1
) (
    input  logic            clk,
    input  logic            rst,
    lut_cfg_loader_if.slave bus
);
    localparam int DEPTH = lut_depth(LUT_INPUTS);
`ifdef LUT_CFG_PARITY_EN
    localparam int FRAME_LEN = DEPTH + 1;
`else
    localparam int FRAME_LEN = DEPTH;
`endif
    localparam int CNT_W  = LUT_INPUTS + 1;
    localparam int HOLD_W = (WR_HOLD > 1) ? $clog2(WR_HOLD) : 1;

    localparam logic [CNT_W-1:0]      LAST_BIT  = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0]      DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [HOLD_W-1:0]     HOLD_LAST = HOLD_W'(WR_HOLD - 1);
    localparam logic [LUT_INPUTS-1:0] ADDR_LAST = LUT_INPUTS'(DEPTH - 1);

    state_t                state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [HOLD_W-1:0]     hold_cnt;
    logic [LUT_INPUTS-1:0] addr;
    logic                  data;
    logic                  cfg_en;
    logic                  busy;
    logic                  done;

    logic                  wr_en;
    logic [LUT_INPUTS-1:0] rd_idx;
    logic                  rd_bit;

`ifdef LUT_CFG_PARITY_EN
    logic                  err;
    logic                  parity_bit;
    logic                  table_parity;
`endif

    // NOTE: every signal gets a value before any condition, so no path through this block can
    // infer a latch.
    always_comb begin
        wr_en  = 1'b0;
        rd_idx = '0;
        if (state == SHIFT && bus.i_bit_valid && !bus.i_start && bit_cnt < DEPTH_CNT) begin
            wr_en = 1'b1;
        end
        // The read port looks one entry ahead so the next data bit is ready when the address advances.
        if (state == WRITE) begin
            rd_idx = addr + 1'b1;
        end
    end

    lut_cfg_shift_reg #(
        .LUT_INPUTS (LUT_INPUTS)
    ) u_shift_reg (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_idx (bit_cnt[LUT_INPUTS-1:0]),
        .wr_bit (bus.i_bit),
        .rd_idx (rd_idx),
        .rd_bit (rd_bit)
`ifdef LUT_CFG_PARITY_EN
        ,
        .parity (table_parity)
`endif
    );

    // NOTE: all state and registered outputs use non-blocking assignments, so every read in this
    // block sees the value from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            hold_cnt <= '0;
            addr     <= '0;
            data     <= 1'b0;
            cfg_en   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef LUT_CFG_PARITY_EN
            err        <= 1'b0;
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
`ifdef LUT_CFG_PARITY_EN
                        err     <= 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    if (bus.i_start) begin
                        bit_cnt <= '0;
                    end else if (bus.i_bit_valid) begin
                        bit_cnt <= bit_cnt + 1'b1;
`ifdef LUT_CFG_PARITY_EN
                        if (bit_cnt == DEPTH_CNT) begin
                            parity_bit <= bus.i_bit;
                        end
                        if (bit_cnt == LAST_BIT) begin
                            state <= CHECK;
                        end
`else
                        // Entry 0 was captured earlier, so the first write can be presented now.
                        if (bit_cnt == LAST_BIT) begin
                            state  <= WRITE;
                            cfg_en <= 1'b1;
                            addr   <= '0;
                            data   <= rd_bit;
                        end
`endif
                    end
                end
`ifdef LUT_CFG_PARITY_EN
                CHECK: begin
                    if (table_parity == parity_bit) begin
                        state  <= WRITE;
                        cfg_en <= 1'b1;
                        addr   <= '0;
                        data   <= rd_bit;
                    end else begin
                        state <= IDLE;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
`endif
                WRITE: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        if (addr == ADDR_LAST) begin
                            state  <= DONE;
                            cfg_en <= 1'b0;
                            addr   <= '0;
                            data   <= 1'b0;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                        end else begin
                            addr <= addr + 1'b1;
                            data <= rd_bit;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_addr          = addr;
    assign bus.o_data          = data;
    assign bus.o_config_enable = cfg_en;
    assign bus.o_busy          = busy;
    assign bus.o_done          = done;
`ifdef LUT_CFG_PARITY_EN
    assign bus.o_err           = err;
`else
    assign bus.o_err           = 1'b0;
`endif

endmodule

// File: tb/tb_lut_cfg_loader.sv
// Bench for lut_cfg_loader: two instances (WR_HOLD 1 and 3) share one stimulus stream and are
// compared every cycle against a transaction-level model of the expected output sequence.
module tb_lut_cfg_loader;
    import lut_cfg_pkg::*;

    localparam int N      = 4;
    localparam int DEPTH  = 16;
    localparam int HOLD_A = 1;
    localparam int HOLD_B = 3;
`ifdef LUT_CFG_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int FRAME_LEN = DEPTH + (PAR ? 1 : 0);

    typedef struct packed {
        logic         busy;
        logic         done;
        logic         err;
        logic         cfg;
        logic [N-1:0] addr;
        logic         data;
    } out_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic bit_valid = 1'b0;
    logic sbit = 1'b0;

    always #5 clk = ~clk;

    lut_cfg_loader_if #(.LUT_INPUTS(N)) bus_a ();
    lut_cfg_loader_if #(.LUT_INPUTS(N)) bus_b ();

    assign bus_a.i_start     = start;
    assign bus_a.i_bit_valid = bit_valid;
    assign bus_a.i_bit       = sbit;
    assign bus_b.i_start     = start;
    assign bus_b.i_bit_valid = bit_valid;
    assign bus_b.i_bit       = sbit;

    lut_cfg_loader #(.LUT_INPUTS(N), .WR_HOLD(HOLD_A)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    lut_cfg_loader #(.LUT_INPUTS(N), .WR_HOLD(HOLD_B)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    out_t act_a, act_b;
    assign act_a = {bus_a.o_busy, bus_a.o_done, bus_a.o_err, bus_a.o_config_enable, bus_a.o_addr, bus_a.o_data};
    assign act_b = {bus_b.o_busy, bus_b.o_done, bus_b.o_err, bus_b.o_config_enable, bus_b.o_addr, bus_b.o_data};

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    out_t exp_o [2];
    bit   collecting [2];
    bit   err_m [2];
    bit   frame_q [2][$];
    out_t sched [2][$];

    function automatic int hold_of(input int d);
        return (d == 0) ? HOLD_A : HOLD_B;
    endfunction

    // A finished frame expands into the complete list of per-cycle outputs that must follow it.
    task automatic build_schedule(input int d);
        logic [DEPTH-1:0] tbl;
        int   ones;
        out_t e;
        ones = 0;
        for (int i = 0; i < DEPTH; i++) begin
            tbl[i] = frame_q[d][i];
            ones += int'(frame_q[d][i]);
        end
        if (PAR) begin
            e = '0; e.busy = 1'b1;
            sched[d].push_back(e);
            if (int'(frame_q[d][DEPTH]) != (ones % 2)) begin
                err_m[d] = 1'b1;
                e = '0; e.err = 1'b1;
                sched[d].push_back(e);
                return;
            end
        end
        for (int k = 0; k < DEPTH; k++) begin
            for (int h = 0; h < hold_of(d); h++) begin
                e = '0; e.busy = 1'b1; e.cfg = 1'b1; e.addr = N'(k); e.data = tbl[k];
                sched[d].push_back(e);
            end
        end
        e = '0; e.done = 1'b1;
        sched[d].push_back(e);
        e = '0;
        sched[d].push_back(e);
    endtask

    task automatic model_step(input int d);
        if (rst) begin
            collecting[d] = 1'b0;
            err_m[d] = 1'b0;
            frame_q[d].delete();
            sched[d].delete();
            exp_o[d] = '0;
            return;
        end
        if (sched[d].size() > 0) begin
            exp_o[d] = sched[d].pop_front();
            return;
        end
        if (collecting[d]) begin
            if (start) begin
                frame_q[d].delete();
            end else if (bit_valid) begin
                frame_q[d].push_back(sbit);
                if (frame_q[d].size() == FRAME_LEN) begin
                    collecting[d] = 1'b0;
                    build_schedule(d);
                    exp_o[d] = sched[d].pop_front();
                    return;
                end
            end
            exp_o[d] = '0;
            exp_o[d].busy = 1'b1;
            return;
        end
        if (start) begin
            collecting[d] = 1'b1;
            frame_q[d].delete();
            err_m[d] = 1'b0;
            exp_o[d] = '0;
            exp_o[d].busy = 1'b1;
            return;
        end
        exp_o[d] = '0;
        exp_o[d].err = err_m[d];
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("out_hold1", act_a, exp_o[0]);
            check("out_hold3", act_b, exp_o[1]);
        end
    end

    // ---------------- observers of what the LUT would capture ----------------
    int          cyc = 0;
    int          cfg_cnt [2];
    int          done_cnt [2];
    int          busy_on_done [2];
    int          last_cfg_cyc [2];
    int          done_cyc [2];
    logic [DEPTH-1:0] lut_sh [2];

    task automatic observe(input int d, input out_t o);
        if (o.cfg) begin
            cfg_cnt[d]++;
            last_cfg_cyc[d] = cyc;
            lut_sh[d][o.addr] = o.data;
        end
        if (o.done) begin
            done_cnt[d]++;
            done_cyc[d] = cyc;
            if (o.busy) busy_on_done[d]++;
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (chk_en) begin
            observe(0, act_a);
            observe(1, act_b);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse_start(input bit with_bit);
        start = 1'b1;
        bit_valid = with_bit;
        sbit = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bit_valid = 1'b0;
        sbit = 1'b0;
    endtask

    task automatic send_bits(input logic [DEPTH:0] val, input int nbits, input bit gaps);
        for (int i = 0; i < nbits; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            bit_valid = 1'b1;
            sbit = val[i];
            @(negedge clk);
            bit_valid = 1'b0;
            sbit = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [DEPTH-1:0] t, input bit good, input bit gaps);
        logic par;
        par = (^t) ^ ~good;
        pulse_start(1'b0);
        send_bits({par, t}, FRAME_LEN, gaps);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (n < 600 && !(sched[0].size() == 0 && sched[1].size() == 0 &&
                            !collecting[0] && !collecting[1])) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("wait_idle_timeout", 32'(n >= 600), 0);
    endtask

    task automatic wait_write_addr(input logic [N-1:0] a);
        int n = 0;
        while (n < 200 && !(bus_a.o_config_enable && bus_a.o_addr == a)) begin
            @(negedge clk);
            n++;
        end
        check("wait_addr_timeout", 32'(n >= 200), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed and random sequences ----------------
    initial begin
        int c0, c1, d0, d1;
        logic [DEPTH-1:0] cur_tbl;
        logic [DEPTH-1:0] t;
        bit good;
        for (int d = 0; d < 2; d++) begin
            cfg_cnt[d] = 0; done_cnt[d] = 0; busy_on_done[d] = 0;
            last_cfg_cyc[d] = 0; done_cyc[d] = 0; lut_sh[d] = '0;
        end

        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_outputs_hold1", act_a, 0);
        check("reset_outputs_hold3", act_b, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Frame 0xA5C3, bit 0 first
        c0 = cfg_cnt[0]; c1 = cfg_cnt[1]; d0 = done_cnt[0]; d1 = done_cnt[1];
        send_frame(16'hA5C3, 1'b1, 1'b0);
        wait_idle();
        check("t1_table_hold1", lut_sh[0], 16'hA5C3);
        check("t1_cfg_cycles_hold1", cfg_cnt[0] - c0, 16);
        check("t1_done_count_hold1", done_cnt[0] - d0, 1);
        check("t1_done_after_last_write", done_cyc[0] - last_cfg_cyc[0], 1);
        check("t1_cfg_cycles_hold3", cfg_cnt[1] - c1, 48);
        check("t1_done_count_hold3", done_cnt[1] - d1, 1);

        // Frame 0xFFFF with gaps between bits
        c1 = cfg_cnt[1];
        send_frame(16'hFFFF, 1'b1, 1'b1);
        wait_idle();
        check("t2_table_hold3", lut_sh[1], 16'hFFFF);
        check("t2_cfg_cycles_hold3", cfg_cnt[1] - c1, 48);
        check("t2_busy_on_done_hold3", busy_on_done[1], 0);
        check("t2_busy_on_done_hold1", busy_on_done[0], 0);

        // Restart after 7 ones, then 0x0001
        d0 = done_cnt[0];
        pulse_start(1'b0);
        send_bits({(DEPTH+1){1'b1}}, 7, 1'b0);
        send_frame(16'h0001, 1'b1, 1'b0);
        wait_idle();
        check("t3_table_hold1", lut_sh[0], 16'h0001);
        check("t3_table_hold3", lut_sh[1], 16'h0001);
        check("t3_single_done_hold1", done_cnt[0] - d0, 1);

        // Start pulse in the middle of the sweep is ignored
        c0 = cfg_cnt[0]; d0 = done_cnt[0]; d1 = done_cnt[1];
        send_frame(16'h3C5A, 1'b1, 1'b0);
        wait_write_addr(4'd5);
        pulse_start(1'b1);
        wait_idle();
        check("t4_table_hold1", lut_sh[0], 16'h3C5A);
        check("t4_cfg_cycles_hold1", cfg_cnt[0] - c0, 16);
        check("t4_single_done_hold1", done_cnt[0] - d0, 1);
        check("t4_single_done_hold3", done_cnt[1] - d1, 1);
        cur_tbl = 16'h3C5A;

`ifdef LUT_CFG_PARITY_EN
        // Bad parity: 0x0007 with parity bit 0
        c0 = cfg_cnt[0]; d0 = done_cnt[0];
        send_frame(16'h0007, 1'b0, 1'b0);
        wait_idle();
        check("t5_err_hold1", bus_a.o_err, 1);
        check("t5_err_hold3", bus_b.o_err, 1);
        check("t5_no_writes", cfg_cnt[0] - c0, 0);
        check("t5_no_done", done_cnt[0] - d0, 0);
        check("t5_table_kept", lut_sh[0], 16'h3C5A);
        send_frame(16'h1234, 1'b1, 1'b0);
        wait_idle();
        check("t5_err_cleared", bus_a.o_err, 0);
        check("t5_good_table", lut_sh[0], 16'h1234);
        cur_tbl = 16'h1234;
`else
        check("t5_err_tied_low", bus_a.o_err, 0);
`endif

        // Reset while sweeping at address 9
        send_frame(16'h5AA5, 1'b1, 1'b0);
        wait_write_addr(4'd9);
        rst = 1'b1;
        @(negedge clk);
        check("t6_outputs_after_rst_hold1", act_a, 0);
        check("t6_outputs_after_rst_hold3", act_b, 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bit_valid = 1'($urandom);
            sbit = 1'($urandom);
            @(negedge clk);
        end
        bit_valid = 1'b0;
        sbit = 1'b0;
        check("t6_still_idle", act_a, 0);

        // Randomized frames with restarts and ignored traffic during the sweep
        for (int it = 0; it < 25; it++) begin
            t = DEPTH'($urandom);
            good = !PAR || ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 3) == 0) begin
                pulse_start(1'b0);
                send_bits((DEPTH+1)'($urandom), $urandom_range(1, FRAME_LEN - 1), 1'b1);
            end
            send_frame(t, good, 1'($urandom));
            if (good && $urandom_range(0, 3) == 0) begin
                for (int i = 0; i < 10; i++) begin
                    start = 1'($urandom);
                    bit_valid = 1'($urandom);
                    sbit = 1'($urandom);
                    @(negedge clk);
                end
                start = 1'b0;
                bit_valid = 1'b0;
                sbit = 1'b0;
            end
            wait_idle();
            if (good) cur_tbl = t;
            check("rand_table_hold1", lut_sh[0], cur_tbl);
            check("rand_table_hold3", lut_sh[1], cur_tbl);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
